// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and the memory-stage FSM state type
package pipe_pkg;
  localparam int XLEN = 64;
  localparam int MAX_WAIT_DEF = 16;
  typedef enum logic {IDLE, WAIT} lsu_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; load captures all fields, bubble only kills the write enable
module mem_wb_reg
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_bubble,
  input  logic            i_regwrite,
  input  logic            i_resultsrc,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_pcplus4,
  input  logic [XLEN-1:0] i_alu,
  input  logic [XLEN-1:0] i_rdata,
  output logic            o_regwrite,
  output logic            o_resultsrc,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_pcplus4,
  output logic [XLEN-1:0] o_alu,
  output logic [XLEN-1:0] o_rdata
);
  // capture on load, drop only the write enable on bubble so write-back never repeats
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      o_regwrite  <= 1'b0;
      o_resultsrc <= 1'b0;
      o_rd        <= '0;
      o_pcplus4   <= '0;
      o_alu       <= '0;
      o_rdata     <= '0;
    end else if (i_load) begin
      o_regwrite  <= i_regwrite;
      o_resultsrc <= i_resultsrc;
      o_rd        <= i_rd;
      o_pcplus4   <= i_pcplus4;
      o_alu       <= i_alu;
      o_rdata     <= i_rdata;
    end else if (i_bubble) begin
      o_regwrite  <= 1'b0;
    end
endmodule

// File: rtl/memory_cycle_lsu.sv
// memory_cycle_lsu: memory stage with req/ack data port, stall, timeout and MEM/WB register (optional LSU_MISALIGN_CHECK_EN)
module memory_cycle_lsu
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            ResultSrcM,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] ALU_ResultM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            stall_m,
  output logic            bus_err,
  output logic            RegWriteW,
  output logic            ResultSrcW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW
);
  lsu_state_t      r_state, w_next;
  logic [7:0]      r_cnt;
  logic            w_mem_op, w_mis, w_tmo, w_load;
  logic [XLEN-1:0] w_rdata;
  assign w_mem_op = MemWriteM | ResultSrcM;
`ifdef LSU_MISALIGN_CHECK_EN
  assign w_mis = w_mem_op & (r_state == IDLE) & (|ALU_ResultM[2:0]);
`else
  assign w_mis = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  // wait counter: held at zero while idle, counts every cycle spent waiting for ack
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else r_cnt <= (r_state == WAIT) ? r_cnt + 8'd1 : '0;
  // request, stall, timeout and next-state decode; everything is forced low while in reset
  always_comb begin
    dmem_req = rst & ~w_mis & ((r_state == WAIT) | w_mem_op);
    w_tmo    = rst & (r_state == WAIT) & ~dmem_ack & (r_cnt == 8'(MAX_WAIT - 1));
    stall_m  = dmem_req & ~dmem_ack & ~w_tmo;
    bus_err  = w_tmo | (rst & w_mis);
    w_load   = ~stall_m & ~bus_err;
    w_next   = stall_m ? WAIT : IDLE;
  end
  assign dmem_we    = dmem_req & MemWriteM;
  assign dmem_addr  = rst ? ALU_ResultM : '0;
  assign dmem_wdata = rst ? WriteDataM : '0;
  assign w_rdata    = (dmem_req & dmem_ack) ? dmem_rdata : '0;
  mem_wb_reg u_mem_wb (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_bubble    (~w_load),
    .i_regwrite  (RegWriteM),
    .i_resultsrc (ResultSrcM),
    .i_rd        (RD_M),
    .i_pcplus4   (PCPlus4M),
    .i_alu       (ALU_ResultM),
    .i_rdata     (w_rdata),
    .o_regwrite  (RegWriteW),
    .o_resultsrc (ResultSrcW),
    .o_rd        (RD_W),
    .o_pcplus4   (PCPlus4W),
    .o_alu       (ALU_ResultW),
    .o_rdata     (ReadDataW)
  );
endmodule

// File: tb/tb_memory_cycle_lsu.sv
// tb_memory_cycle_lsu: directed self-checking bench for the memory stage
`timescale 1ns/1ps
module tb_memory_cycle_lsu;
  logic        clk, rst, RegWriteM, MemWriteM, ResultSrcM, dmem_ack;
  logic [4:0]  RD_M;
  logic [63:0] PCPlus4M, WriteDataM, ALU_ResultM, dmem_rdata;
  logic        dmem_req, dmem_we, stall_m, bus_err, RegWriteW, ResultSrcW;
  logic [63:0] dmem_addr, dmem_wdata, PCPlus4W, ALU_ResultW, ReadDataW;
  logic [4:0]  RD_W;
  int n_tests = 0;
  int n_fail = 0;

  memory_cycle_lsu dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_m(stall_m), .bus_err(bus_err),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_in();
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = 0; PCPlus4M = 0;
    WriteDataM = 0; ALU_ResultM = 0; dmem_rdata = 0; dmem_ack = 0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    #1 rst = 1'b0;
    MemWriteM = 1; ALU_ResultM = 64'h108; WriteDataM = 64'h55;
    #2;
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0h exp 0", dmem_req); end
    n_tests++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0h exp 0", stall_m); end
    n_tests++; if (dmem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr got %0h exp 0", dmem_addr); end
    n_tests++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL reset_regwritew got %0h exp 0", RegWriteW); end
    n_tests++; if (ReadDataW !== 64'h0) begin n_fail++; $display("FAIL reset_readdataw got %0h exp 0", ReadDataW); end
    idle_in();
    @(negedge clk) rst = 1'b1;
    edge1();
  endtask

  task automatic test_alu();
    RegWriteM = 1; RD_M = 5; ALU_ResultM = 64'h2A; PCPlus4M = 64'h1004;
    dmem_ack = 1; dmem_rdata = 64'hBAD;
    @(negedge clk);
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL alu_req got %0h exp 0", dmem_req); end
    n_tests++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %0h exp 0", stall_m); end
    edge1();
    n_tests++; if (RegWriteW !== 1'b1) begin n_fail++; $display("FAIL alu_regwritew got %0h exp 1", RegWriteW); end
    n_tests++; if (RD_W !== 5'd5) begin n_fail++; $display("FAIL alu_rdw got %0h exp 5", RD_W); end
    n_tests++; if (ALU_ResultW !== 64'h2A) begin n_fail++; $display("FAIL alu_resultw got %0h exp 2a", ALU_ResultW); end
    n_tests++; if (PCPlus4W !== 64'h1004) begin n_fail++; $display("FAIL alu_pcplus4w got %0h exp 1004", PCPlus4W); end
    n_tests++; if (ReadDataW !== 64'h0) begin n_fail++; $display("FAIL alu_ack_ignored got %0h exp 0", ReadDataW); end
    idle_in();
  endtask

  task automatic test_load_hit();
    RegWriteM = 1; ResultSrcM = 1; RD_M = 7; ALU_ResultM = 64'h100; PCPlus4M = 64'h2004;
    dmem_ack = 1; dmem_rdata = 64'hDEADBEEF;
    @(negedge clk);
    n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL ld_req got %0h exp 1", dmem_req); end
    n_tests++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL ld_we got %0h exp 0", dmem_we); end
    n_tests++; if (dmem_addr !== 64'h100) begin n_fail++; $display("FAIL ld_addr got %0h exp 100", dmem_addr); end
    n_tests++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL ld_stall got %0h exp 0", stall_m); end
    edge1();
    n_tests++; if (ReadDataW !== 64'hDEADBEEF) begin n_fail++; $display("FAIL ld_readdataw got %0h exp deadbeef", ReadDataW); end
    n_tests++; if (ResultSrcW !== 1'b1) begin n_fail++; $display("FAIL ld_resultsrcw got %0h exp 1", ResultSrcW); end
    n_tests++; if (RegWriteW !== 1'b1) begin n_fail++; $display("FAIL ld_regwritew got %0h exp 1", RegWriteW); end
    n_tests++; if (RD_W !== 5'd7) begin n_fail++; $display("FAIL ld_rdw got %0h exp 7", RD_W); end
    idle_in();
  endtask

  task automatic test_store_wait();
    MemWriteM = 1; ALU_ResultM = 64'h108; WriteDataM = 64'h55; PCPlus4M = 64'h3004;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      @(negedge clk);
      n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL st_req[%0d] got %0h exp 1", i, dmem_req); end
      n_tests++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL st_we[%0d] got %0h exp 1", i, dmem_we); end
      n_tests++; if (dmem_addr !== 64'h108) begin n_fail++; $display("FAIL st_addr[%0d] got %0h exp 108", i, dmem_addr); end
      n_tests++; if (dmem_wdata !== 64'h55) begin n_fail++; $display("FAIL st_wdata[%0d] got %0h exp 55", i, dmem_wdata); end
      n_tests++; if (stall_m !== (i < 3)) begin n_fail++; $display("FAIL st_stall[%0d] got %0h exp %0h", i, stall_m, (i < 3)); end
      edge1();
      n_tests++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL st_regwritew[%0d] got %0h exp 0", i, RegWriteW); end
      if (i == 0) begin
        n_tests++; if (RD_W !== 5'd7) begin n_fail++; $display("FAIL st_bubble_hold got %0h exp 7", RD_W); end
      end
    end
    n_tests++; if (ALU_ResultW !== 64'h108) begin n_fail++; $display("FAIL st_resultw got %0h exp 108", ALU_ResultW); end
    n_tests++; if (PCPlus4W !== 64'h3004) begin n_fail++; $display("FAIL st_pcplus4w got %0h exp 3004", PCPlus4W); end
    idle_in();
    @(negedge clk);
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL st_after_req got %0h exp 0", dmem_req); end
    edge1();
  endtask

  task automatic test_back_to_back();
    RegWriteM = 1; ResultSrcM = 1; RD_M = 3; ALU_ResultM = 64'h200;
    @(negedge clk);
    n_tests++; if (stall_m !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_a got %0h exp 1", stall_m); end
    edge1();
    dmem_ack = 1; dmem_rdata = 64'h1111;
    @(negedge clk);
    n_tests++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_b got %0h exp 0", stall_m); end
    edge1();
    n_tests++; if (ReadDataW !== 64'h1111) begin n_fail++; $display("FAIL b2b_data_a got %0h exp 1111", ReadDataW); end
    n_tests++; if (RD_W !== 5'd3) begin n_fail++; $display("FAIL b2b_rd_a got %0h exp 3", RD_W); end
    RD_M = 4; ALU_ResultM = 64'h300; dmem_rdata = 64'h2222;
    @(negedge clk);
    n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req_c got %0h exp 1", dmem_req); end
    n_tests++; if (dmem_addr !== 64'h300) begin n_fail++; $display("FAIL b2b_addr_c got %0h exp 300", dmem_addr); end
    edge1();
    n_tests++; if (ReadDataW !== 64'h2222) begin n_fail++; $display("FAIL b2b_data_c got %0h exp 2222", ReadDataW); end
    n_tests++; if (RD_W !== 5'd4) begin n_fail++; $display("FAIL b2b_rd_c got %0h exp 4", RD_W); end
    n_tests++; if (RegWriteW !== 1'b1) begin n_fail++; $display("FAIL b2b_regwrite_c got %0h exp 1", RegWriteW); end
    idle_in();
  endtask

  task automatic test_timeout();
    int stalls = 0;
    RegWriteM = 1; ResultSrcM = 1; RD_M = 9; ALU_ResultM = 64'h400;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (stall_m === 1'b1) stalls++;
      n_tests++; if (bus_err !== (i == 16)) begin n_fail++; $display("FAIL to_buserr[%0d] got %0h exp %0h", i, bus_err, (i == 16)); end
      n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL to_req[%0d] got %0h exp 1", i, dmem_req); end
      edge1();
      n_tests++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL to_regwritew[%0d] got %0h exp 0", i, RegWriteW); end
    end
    n_tests++; if (stalls !== 16) begin n_fail++; $display("FAIL to_stall_cycles got %0d exp 16", stalls); end
    idle_in();
    @(negedge clk);
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_buserr_after got %0h exp 0", bus_err); end
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_after got %0h exp 0", dmem_req); end
    edge1();
  endtask

  task automatic test_reset_mid();
    RegWriteM = 1; RD_M = 12; ALU_ResultM = 64'h77; PCPlus4M = 64'h4004;
    edge1();
    ResultSrcM = 1; RD_M = 13; ALU_ResultM = 64'h500;
    edge1();
    edge1();
    @(negedge clk);
    n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_before got %0h exp 1", dmem_req); end
    n_tests++; if (RD_W !== 5'd12) begin n_fail++; $display("FAIL rm_rdw_before got %0h exp c", RD_W); end
    rst = 1'b0;
    #1;
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req got %0h exp 0", dmem_req); end
    n_tests++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL rm_stall got %0h exp 0", stall_m); end
    n_tests++; if (RD_W !== 5'd0) begin n_fail++; $display("FAIL rm_rdw got %0h exp 0", RD_W); end
    n_tests++; if (ALU_ResultW !== 64'h0) begin n_fail++; $display("FAIL rm_resultw got %0h exp 0", ALU_ResultW); end
    n_tests++; if (PCPlus4W !== 64'h0) begin n_fail++; $display("FAIL rm_pcplus4w got %0h exp 0", PCPlus4W); end
    dmem_ack = 1; dmem_rdata = 64'h99;
    edge1();
    @(negedge clk);
    rst = 1'b1;
    RegWriteM = 0; ResultSrcM = 0; RD_M = 0; ALU_ResultM = 0; PCPlus4M = 0;
    #1;
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_after got %0h exp 0", dmem_req); end
    edge1();
    n_tests++; if (ReadDataW !== 64'h0) begin n_fail++; $display("FAIL rm_late_ack got %0h exp 0", ReadDataW); end
    n_tests++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL rm_regwritew got %0h exp 0", RegWriteW); end
    idle_in();
  endtask

  task automatic test_misalign();
    RegWriteM = 1; ResultSrcM = 1; RD_M = 14; ALU_ResultM = 64'h104;
`ifdef LSU_MISALIGN_CHECK_EN
    @(negedge clk);
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req got %0h exp 0", dmem_req); end
    n_tests++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL mis_stall got %0h exp 0", stall_m); end
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL mis_buserr got %0h exp 1", bus_err); end
    edge1();
    n_tests++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL mis_regwritew got %0h exp 0", RegWriteW); end
    idle_in();
    @(negedge clk);
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL mis_buserr_after got %0h exp 0", bus_err); end
    edge1();
`else
    dmem_ack = 1; dmem_rdata = 64'hABCD;
    @(negedge clk);
    n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL mis_req got %0h exp 1", dmem_req); end
    n_tests++; if (dmem_addr !== 64'h104) begin n_fail++; $display("FAIL mis_addr got %0h exp 104", dmem_addr); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL mis_buserr got %0h exp 0", bus_err); end
    edge1();
    n_tests++; if (ReadDataW !== 64'hABCD) begin n_fail++; $display("FAIL mis_readdataw got %0h exp abcd", ReadDataW); end
    n_tests++; if (RegWriteW !== 1'b1) begin n_fail++; $display("FAIL mis_regwritew got %0h exp 1", RegWriteW); end
    idle_in();
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_hit();
    test_store_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_cycle_lsu.md
Name: memory_cycle_lsu

Overview:
Memory stage of the 64-bit 5-stage pipeline. It consumes the EX/MEM register outputs (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM) and drives a req/ack data-memory port. It stalls the upstream pipeline while an access is outstanding and owns the MEM/WB pipeline register that feeds write-back.

Parameters:
XLEN, 64, data/address width.
MAX_WAIT, 16, cycles an access may wait for dmem_ack before a bus error is declared (range 1..255).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
RegWriteM  in  1  register write enable of the M-stage instruction.
MemWriteM  in  1  store.
ResultSrcM  in  1  1 = load (write-back selects memory data).
RD_M  in  5  destination register.
PCPlus4M  in  XLEN  PC+4 of the M-stage instruction.
WriteDataM  in  XLEN  store data.
ALU_ResultM  in  XLEN  effective address, or ALU result.
dmem_req  out  1  access request.
dmem_we  out  1  1 = write.
dmem_addr  out  XLEN  access address (= ALU_ResultM).
dmem_wdata  out  XLEN  store data (= WriteDataM).
dmem_rdata  in  XLEN  load data, valid when dmem_ack=1.
dmem_ack  in  1  access complete.
stall_m  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers.
bus_err  out  1  one-cycle pulse: timeout (or misalignment) on completion.
RegWriteW  out  1  MEM/WB register write enable.
ResultSrcW  out  1  MEM/WB result select.
RD_W  out  5  MEM/WB destination.
PCPlus4W  out  XLEN  MEM/WB PC+4.
ALU_ResultW  out  XLEN  MEM/WB ALU result.
ReadDataW  out  XLEN  MEM/WB load data.

Behaviour:
- mem_op = MemWriteM | ResultSrcM. MemWriteM has priority: if both are 1, the access is a store.
- FSM states are IDLE and WAIT. All outputs are 0 on reset. Reset mid-access returns the FSM to IDLE and drops dmem_req at once; no write-back occurs.
- IDLE with mem_op=0: dmem_req=0, stall_m=0. MEM/WB loads the inputs on the next edge, with ReadDataW=0. Latency is 1 cycle.
- IDLE with mem_op=1:
  - dmem_req=1 combinationally; dmem_we=MemWriteM; addr and wdata are taken from the inputs.
  - If dmem_ack=1 in the same cycle, the access completes: stall_m=0 and MEM/WB captures the inputs plus ReadDataW=dmem_rdata.
  - Otherwise stall_m=1, go to WAIT and clear wait_cnt.
- WAIT:
  - dmem_req=1 with stable addr/we/wdata (inputs are frozen by stall_m). wait_cnt increments each cycle.
  - On dmem_ack=1: complete as above, stall_m=0, return to IDLE.
  - If wait_cnt reaches MAX_WAIT-1 with no ack: abort. bus_err pulses, MEM/WB loads a bubble (RegWriteW=0), stall_m=0, return to IDLE.
- Any cycle with stall_m=1 loads a bubble into MEM/WB: RegWriteW=0, other fields hold. Write-back therefore never repeats.
- dmem_ack while dmem_req=0 is ignored.
- Stores complete with RegWriteW as supplied (normally 0).
- Back-to-back memory ops: the second op's request is issued in the cycle after the first completes. There are no idle bubbles.

Optional Feature:
LSU_MISALIGN_CHECK_EN.
- Defined: a mem_op with ALU_ResultM[2:0]!=0 issues no request (dmem_req=0) and causes no stall. It completes in 1 cycle as a bubble (RegWriteW=0) with bus_err=1.
- Undefined: the address is passed unchanged and alignment is the memory's concern.

Decomposition:
- Shared package pipe_pkg holds:
  - the XLEN constant;
  - the lsu_state_t enum {IDLE, WAIT};
  - the MAX_WAIT default.
- One natural sub-module is mem_wb_reg: the async-reset MEM/WB register with load and bubble inputs. The FSM and wait counter stay in memory_cycle_lsu.

Test Plan:
- ALU op (RegWriteM=1, RD_M=5, ALU_ResultM=0x2A) -> next cycle RegWriteW=1, RD_W=5, ALU_ResultW=0x2A; dmem_req never asserted.
- Load at 0x100, ack in the same cycle with rdata=0xDEADBEEF -> stall_m=0 throughout; next cycle ReadDataW=0xDEADBEEF, ResultSrcW=1.
- Store at 0x108 with wdata=0x55 and ack after 3 cycles -> dmem_req=1 and dmem_we=1 for 4 cycles with stable addr/wdata; stall_m=1 for 3 cycles; RegWriteW=0 throughout.
- Load with no ack, MAX_WAIT=16 -> stall_m high for 16 cycles, then bus_err pulses once and RegWriteW stays 0; the FSM returns to IDLE.
- rst asserted in WAIT on cycle 2 -> dmem_req=0, stall_m=0 and all W outputs 0 immediately; a later ack is ignored.
- With LSU_MISALIGN_CHECK_EN, load at 0x104 -> dmem_req=0, bus_err=1 for one cycle, RegWriteW=0.
